// File: rtl/mam_pkg.sv
// mam_pkg: shared state encoding and beat-count width for the MAM memory responder
package mam_pkg;
    localparam int BEAT_W = 14;
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
endpackage

// File: rtl/mam_mem_sram.sv
// mam_mem_sram: single-port word array with per-byte write enables and a registered read port
module mam_mem_sram #(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_WORDS  = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic                         we,
    input  logic [DATA_WIDTH/8-1:0]      be,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         re,
    output logic [DATA_WIDTH-1:0]        rdata
);
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    always_ff @(posedge clk)
        if (we)
            for (int i = 0; i < DATA_WIDTH/8; i++)
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    // only the read register is reset; the array keeps its contents
    always_ff @(posedge clk or posedge rst)
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[addr];
endmodule

// File: rtl/mam_mem_responder.sv
// mam_mem_responder: MAM system-bus memory endpoint with byte-enabled array and per-beat wait states
module mam_mem_responder import mam_pkg::*; #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_rw,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_burst,
    input  logic [BEAT_W-1:0]       req_beats,
    input  logic                    write_valid,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strb,
    output logic                    write_ready,
    output logic                    read_valid,
    output logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    read_ready,
    output logic                    addr_err
);
    localparam int BYTES = DATA_WIDTH/8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_WORDS);
    localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_WORDS*BYTES);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [BEAT_W-1:0] cnt;
    logic [3:0]        wcnt;
    logic [BEAT_W-1:0] beats;
    logic              req_hs, wr_hs, rd_ld, rd_done, oob;

    assign beats       = (req_burst && req_beats != '0) ? req_beats : BEAT_W'(1);
    assign oob         = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= LIMIT);
    assign req_hs      = req_valid && req_ready;
    assign write_ready = (state == WRITE) && (wcnt == '0);
    assign wr_hs       = write_valid && write_ready;
    // the output register refills as soon as it is empty or being drained
    assign rd_ld       = (state == READ) && (wcnt == '0) && (cnt != '0) && (!read_valid || read_ready);
    assign rd_done     = (state == READ) && read_valid && read_ready && (cnt == '0);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
            wcnt       <= '0;
            idx        <= '0;
            cnt        <= '0;
        end else begin
            wcnt <= (req_hs || wr_hs || rd_ld) ? WAIT : (wcnt != '0 ? wcnt - 1'b1 : wcnt);
            if (state == IDLE && !req_hs) req_ready <= 1'b1;
            if (req_hs) begin
                state     <= req_rw ? WRITE : READ;
                req_ready <= 1'b0;
                idx       <= IW'((req_addr - BASE_ADDR) >> SHIFT);
                cnt       <= beats;
                if (oob) addr_err <= 1'b1;
            end
            if (wr_hs) begin
                idx <= idx + 1'b1;
                cnt <= cnt - 1'b1;
                if (cnt == BEAT_W'(1)) begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            end
            if (rd_ld) begin
                idx        <= idx + 1'b1;
                cnt        <= cnt - 1'b1;
                read_valid <= 1'b1;
            end else if (read_ready) read_valid <= 1'b0;
            if (rd_done) begin
                state     <= IDLE;
                req_ready <= 1'b1;
            end
        end

    mam_mem_sram #(.DATA_WIDTH(DATA_WIDTH), .MEM_WORDS(MEM_WORDS)) u_sram (
        .clk   (clk),
        .rst   (rst),
        .addr  (idx),
        .we    (wr_hs),
        .be    (write_strb),
        .wdata (write_data),
        .re    (rd_ld),
        .rdata (read_data)
    );
endmodule

// File: tb/tb_mam_mem_responder.sv
// tb_mam_mem_responder: scoreboard bench for the responder with WAIT_CYCLES 0 and 3 instances
module tb_mam_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid[2], req_ready[2], req_rw[2], req_burst[2];
    logic        write_valid[2], write_ready[2], read_valid[2], read_ready[2], addr_err[2];
    logic [31:0] req_addr[2];
    logic [13:0] req_beats[2];
    logic [15:0] write_data[2], read_data[2];
    logic [1:0]  write_strb[2];

    for (genvar g = 0; g < 2; g++) begin : u
        mam_mem_responder #(.WAIT_CYCLES(g*3)) dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid   (req_valid[g]),
            .req_ready   (req_ready[g]),
            .req_rw      (req_rw[g]),
            .req_addr    (req_addr[g]),
            .req_burst   (req_burst[g]),
            .req_beats   (req_beats[g]),
            .write_valid (write_valid[g]),
            .write_data  (write_data[g]),
            .write_strb  (write_strb[g]),
            .write_ready (write_ready[g]),
            .read_valid  (read_valid[g]),
            .read_data   (read_data[g]),
            .read_ready  (read_ready[g]),
            .addr_err    (addr_err[g])
        );
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] m[2][256];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    bit          stalled[2];
    logic [15:0] held[2];
    logic [15:0] ev;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'((a >> 1) & 32'hff);
    endfunction

    function automatic int qsz(input int d);
        return d == 0 ? q0.size() : q1.size();
    endfunction

    task automatic push(input int d, input logic [15:0] v);
        if (d == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    task automatic push_model(input int d, input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) push(d, m[d][(idx(a) + i) % 256]);
    endtask

    // read-side monitor: pops the scoreboard on each consumed beat and checks stall stability
    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            if (!rst && read_valid[d]) begin
                if (stalled[d]) chk(read_data[d] == held[d], "read_data_stable", read_data[d], held[d]);
                stalled[d] = !read_ready[d];
                held[d] = read_data[d];
                if (read_ready[d]) begin
                    if (qsz(d) == 0) chk(1'b0, "unexpected_beat", read_data[d], 0);
                    else begin
                        ev = d == 0 ? q0.pop_front() : q1.pop_front();
                        chk(read_data[d] == ev, d == 0 ? "read_data_w0" : "read_data_w3", read_data[d], ev);
                    end
                end
            end else stalled[d] = 1'b0;

    task automatic req(input int d, input bit rw, input logic [31:0] a, input bit burst, input int beats);
        int k = 0;
        req_valid[d] = 1'b1; req_rw[d] = rw; req_addr[d] = a; req_burst[d] = burst; req_beats[d] = 14'(beats);
        @(negedge clk);
        while (!req_ready[d] && k < 50) begin k++; @(negedge clk); end
        if (!req_ready[d]) chk(1'b0, "req_ready_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [31:0] a, input bit burst, input int beats, input int n,
                      input logic [15:0] d0, input logic [1:0] s, input int gap, input bit fin, output int stall);
        int k;
        logic [15:0] v;
        req(d, 1'b1, a, burst, beats);
        stall = 0;
        for (int b = 0; b < n; b++) begin
            v = d0 + 16'(b);
            write_valid[d] = 1'b1; write_data[d] = v; write_strb[d] = s;
            k = 0;
            @(negedge clk);
            while (!write_ready[d] && k < 50) begin stall++; k++; @(negedge clk); end
            if (!write_ready[d]) chk(1'b0, "write_ready_timeout", 0, 1);
            @(posedge clk); #1;
            write_valid[d] = 1'b0;
            if (s[0]) m[d][(idx(a) + b) % 256][7:0] = v[7:0];
            if (s[1]) m[d][(idx(a) + b) % 256][15:8] = v[15:8];
            repeat (gap) begin @(posedge clk); #1; end
        end
        if (fin) begin
            @(negedge clk);
            chk(req_ready[d] == 1'b1, "req_ready_after_write", req_ready[d], 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input int d, input logic [31:0] a, input bit burst, input int beats,
                      input logic [15:0] pat, input int plen, output int lat, output int gaps);
        int k = 0;
        bit seen = 1'b0;
        req(d, 1'b0, a, burst, beats);
        lat = -1; gaps = 0;
        while (qsz(d) != 0 && k < 300) begin
            read_ready[d] = pat[k % plen];
            @(negedge clk);
            k++;
            if (k == 1) chk(req_ready[d] == 1'b0, "req_ready_busy", req_ready[d], 0);
            if (!seen && read_valid[d]) begin seen = 1'b1; lat = k - 1; end
            else if (seen && !read_valid[d]) gaps++;
            @(posedge clk); #1;
        end
        chk(qsz(d) == 0, "read_beats_timeout", qsz(d), 0);
        read_ready[d] = 1'b0;
        @(negedge clk);
        chk(req_ready[d] == 1'b1, "req_ready_after_read", req_ready[d], 1);
        @(posedge clk); #1;
    endtask

    task automatic reset_outputs(input string name);
        for (int d = 0; d < 2; d++) begin
            chk(req_ready[d] == 1'b0, {name, "_req_ready"}, req_ready[d], 0);
            chk(write_ready[d] == 1'b0, {name, "_write_ready"}, write_ready[d], 0);
            chk(read_valid[d] == 1'b0, {name, "_read_valid"}, read_valid[d], 0);
            chk(read_data[d] == 16'h0, {name, "_read_data"}, read_data[d], 0);
            chk(addr_err[d] == 1'b0, {name, "_addr_err"}, addr_err[d], 0);
        end
    endtask

    task automatic release_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk(req_ready[d] == 1'b1, "req_ready_after_reset", req_ready[d], 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, gaps, st;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 0; req_rw[d] = 0; req_addr[d] = 0; req_burst[d] = 0; req_beats[d] = 0;
            write_valid[d] = 0; write_data[d] = 0; write_strb[d] = 0; read_ready[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset_outputs("reset");
        release_reset();

        wr(0, 32'h0, 1'b0, 1, 1, 16'h000f, 2'b11, 0, 1'b1, st);
        push(0, 16'h000f);
        rd(0, 32'h0, 1'b0, 1, 16'h1, 1, lat, gaps);
        chk(lat == 1, "read_latency_w0", lat, 1);

        wr(0, 32'h0, 1'b1, 7, 7, 16'h0000, 2'b11, 0, 1'b1, st);
        chk(st == 0, "write_stall_w0", st, 0);
        for (int i = 0; i < 7; i++) push(0, 16'(i));
        rd(0, 32'h0, 1'b1, 7, 16'h1, 1, lat, gaps);
        chk(gaps == 0, "burst_read_gaps", gaps, 0);

        wr(0, 32'h5e, 1'b1, 6, 6, 16'hc000, 2'b11, 0, 1'b1, st);
        wr(0, 32'h60, 1'b1, 4, 4, 16'hd000, 2'b11, 2, 1'b1, st);
        for (int i = 0; i < 4; i++) push(0, 16'hd000 + 16'(i));
        rd(0, 32'h60, 1'b1, 4, 16'h0059, 7, lat, gaps);
        push(0, 16'hc000);
        for (int i = 0; i < 4; i++) push(0, 16'hd000 + 16'(i));
        push(0, 16'hc005);
        rd(0, 32'h5e, 1'b1, 6, 16'h1, 1, lat, gaps);

        wr(0, 32'h10, 1'b0, 1, 1, 16'haaaa, 2'b11, 0, 1'b1, st);
        wr(0, 32'h10, 1'b0, 1, 1, 16'h55ff, 2'b10, 0, 1'b1, st);
        push(0, 16'h55aa);
        rd(0, 32'h10, 1'b0, 1, 16'h1, 1, lat, gaps);
        wr(0, 32'h20, 1'b1, 0, 1, 16'h7777, 2'b11, 0, 1'b1, st);
        push(0, 16'h7777);
        rd(0, 32'h20, 1'b1, 0, 16'h1, 1, lat, gaps);
        wr(0, 32'h4, 1'b0, 1, 1, 16'he002, 2'b11, 0, 1'b1, st);
        wr(0, 32'h1fe, 1'b1, 3, 3, 16'hf000, 2'b11, 0, 1'b1, st);
        chk(addr_err[0] == 1'b0, "addr_err_last_word", addr_err[0], 0);
        push(0, 16'hf000); push(0, 16'hf001); push(0, 16'hf002); push(0, 16'he002);
        rd(0, 32'h1fe, 1'b1, 4, 16'h1, 1, lat, gaps);

        chk(addr_err[1] == 1'b0, "addr_err_clear_w3", addr_err[1], 0);
        wr(1, 32'h0, 1'b1, 2, 2, 16'h1234, 2'b11, 0, 1'b1, st);
        chk(st == 6, "write_stall_w3", st, 6);
        push(1, 16'h1234); push(1, 16'h1235);
        rd(1, 32'h0, 1'b1, 2, 16'h1, 1, lat, gaps);
        chk(lat == 4, "read_latency_w3", lat, 4);
        chk(gaps == 3, "read_gap_w3", gaps, 3);
        wr(1, 32'h400, 1'b0, 1, 1, 16'h9999, 2'b11, 0, 1'b1, st);
        chk(addr_err[1] == 1'b1, "addr_err_set", addr_err[1], 1);
        push(1, 16'h9999);
        rd(1, 32'h0, 1'b0, 1, 16'h1, 1, lat, gaps);
        chk(addr_err[1] == 1'b1, "addr_err_sticky", addr_err[1], 1);

        wr(0, 32'h40, 1'b1, 16, 16, 16'h1000, 2'b11, 0, 1'b1, st);
        push_model(0, 32'h40, 16);
        rd(0, 32'h40, 1'b1, 16, 16'h1, 1, lat, gaps);
        wr(0, 32'h40, 1'b1, 16, 5, 16'h2000, 2'b11, 0, 1'b0, st);
        #2 rst = 1'b1;
        #1;
        reset_outputs("async_reset");
        @(posedge clk); #1;
        release_reset();
        for (int i = 0; i < 5; i++) push(0, 16'h2000 + 16'(i));
        for (int i = 5; i < 16; i++) push(0, 16'h1000 + 16'(i));
        rd(0, 32'h40, 1'b1, 16, 16'h1, 1, lat, gaps);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
